// File: rtl/fir_pkg.sv
// Shared FIR datapath constants and sample types.
// No logic; used by the FIR core and its downstream requantiser.
// No flow control.
package fir_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int FIR_OUT_W      = 34;
  localparam int FIR_GAIN_SHIFT = 17;
  localparam int SAT_CNT_W      = 16;

  typedef logic signed [SAMPLE_W-1:0]  sample_t;
  typedef logic signed [FIR_OUT_W-1:0] fir_acc_t;

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up arithmetic right shift followed by a clamp to OUT_W signed.
// Latency: purely combinational.
// Backpressure: none; the caller owns all registers and handshakes.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int IN_W  = FIR_OUT_W,
  parameter int OUT_W = SAMPLE_W,
  parameter int SHIFT = FIR_GAIN_SHIFT
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             sat
);

  // One extra bit of headroom so adding the rounding constant never wraps.
  localparam logic [IN_W:0] ONE  = {{IN_W{1'b0}}, 1'b1};
  // Half an output LSB; shifting up then down yields zero when SHIFT is 0.
  localparam logic [IN_W:0] HALF = (ONE << SHIFT) >> 1;
  localparam int            HI_W = IN_W - OUT_W + 2;

  logic [IN_W:0] rnd_dat;
  logic [IN_W:0] shf_dat;
  logic [HI_W-1:0] hi_bits;

  // Round, shift, then clamp when the bits above the output sign are not a pure sign extension.
  always_comb begin
    rnd_dat = {din[IN_W-1], din} + HALF;
    shf_dat = $signed(rnd_dat) >>> SHIFT;
    hi_bits = shf_dat[IN_W:OUT_W-1];
    dout    = shf_dat[OUT_W-1:0];
    sat     = 1'b0;
    if ((hi_bits != '0) && (hi_bits != '1)) begin
      sat = 1'b1;
      if (shf_dat[IN_W]) begin
        dout = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        dout = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/fir_requant.sv
// Requantises the full-precision FIR output to a 16-bit sample and counts clamps.
// Latency: sample accepted in cycle c is presented on the output in cycle c+2.
// Backpressure: two-entry skid-free pipeline; input ready drops only when both stages hold data and the output stalls.
module fir_requant
  import fir_pkg::*;
#(
  parameter int IN_W  = FIR_OUT_W,
  parameter int OUT_W = SAMPLE_W,
  parameter int SHIFT = FIR_GAIN_SHIFT
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 s_axis_data_tvalid,
  output logic                 s_axis_data_tready,
  input  logic [IN_W-1:0]      s_axis_data_tdata,
  output logic                 m_axis_data_tvalid,
  input  logic                 m_axis_data_tready,
  output logic [OUT_W-1:0]     m_axis_data_tdata,
  input  logic                 sat_clear,
  output logic [SAT_CNT_W-1:0] sat_count
);

  logic            s1_vld;
  logic [IN_W-1:0] s1_dat;
  logic            adv1;
  logic            adv2;
  logic [OUT_W-1:0] rs_dat;
  logic            rs_sat;
  logic            sat_evt;

  // The output register moves when empty or draining; stage 1 moves when empty or handing off.
  assign adv2               = !m_axis_data_tvalid || m_axis_data_tready;
  assign adv1               = !s1_vld || adv2;
  assign s_axis_data_tready = adv1 && !areset;
  assign sat_evt            = adv2 && s1_vld && rs_sat;

  fir_round_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .din  (s1_dat),
    .dout (rs_dat),
    .sat  (rs_sat)
  );

  // Stage 1 captures the raw accumulator value on every accepted transfer.
  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else if (adv1) begin
      s1_vld <= s_axis_data_tvalid;
      if (s_axis_data_tvalid) begin
        s1_dat <= s_axis_data_tdata;
      end
    end
  end

  // Output register holds the requantised sample steady while the consumer stalls.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_data_tvalid <= 1'b0;
      m_axis_data_tdata  <= '0;
    end else if (adv2) begin
      m_axis_data_tvalid <= s1_vld;
      if (s1_vld) begin
        m_axis_data_tdata <= rs_dat;
      end
    end
  end

  // Saturation counter: clear wins but still records a clamp landing on the same edge; sticks at all-ones.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= sat_evt ? {{(SAT_CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (sat_evt && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_requant.sv
module tb_fir_requant;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [33:0] s_tdata = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [15:0] m_tdata;
  logic        sat_clear = 1'b0;
  logic [15:0] sat_count;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  bit rnd_rdy = 1'b0;

  // Scoreboard: expected outputs in order, the cycle each was accepted, and observed outputs.
  longint expq[$];
  int     accq[$];
  longint obs[$];
  int     outcyc[$];
  longint sat_acc = 0;

  fir_requant dut (
    .aclk               (aclk),
    .areset             (areset),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .s_axis_data_tdata  (s_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .m_axis_data_tdata  (m_tdata),
    .sat_clear          (sat_clear),
    .sat_count          (sat_count)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: floor((x + 2^16) / 2^17), clamped to the signed 16-bit range.
  function automatic longint ref_raw(input longint x);
    longint r;
    r = x + 65536;
    if (r >= 0) return r / 131072;
    return -((-r + 131071) / 131072);
  endfunction

  function automatic longint ref_out(input longint x);
    longint q;
    q = ref_raw(x);
    if (q > 32767) return 32767;
    if (q < -32768) return -32768;
    return q;
  endfunction

  function automatic bit ref_sat(input longint x);
    longint q;
    q = ref_raw(x);
    return (q > 32767) || (q < -32768);
  endfunction

  // Monitor: inputs are stable here, so handshakes seen now are what the next edge will commit.
  always @(negedge aclk) begin
    bit exp_mv;
    if (areset) begin
      chk("rdy_in_reset", 64'(s_tready), 0);
      expq.delete();
      accq.delete();
    end else begin
      exp_mv = (expq.size() > 0) && (cyc >= accq[0] + 2);
      chk("m_vld", 64'(m_tvalid), longint'(exp_mv));
      if (exp_mv) chk("m_dat", 64'($signed(m_tdata)), expq[0]);
      chk("s_rdy", 64'(s_tready), longint'(!((expq.size() == 2) && !m_tready)));
      if (m_tvalid && m_tready && (expq.size() > 0)) begin
        void'(expq.pop_front());
        void'(accq.pop_front());
        obs.push_back(longint'($signed(m_tdata)));
        outcyc.push_back(cyc);
      end
      if (s_tvalid && s_tready) begin
        expq.push_back(ref_out(longint'($signed(s_tdata))));
        accq.push_back(cyc);
        if (ref_sat(longint'($signed(s_tdata))) && sat_acc < 65535) sat_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    if (rnd_rdy) m_tready = 1'($urandom % 2);
  endtask

  task automatic send(input longint x);
    s_tvalid = 1'b1;
    s_tdata  = x[33:0];
    for (int g = 0; g < 300; g++) begin
      @(negedge aclk);
      if (s_tready) begin
        tick();
        s_tvalid = 1'b0;
        return;
      end
      tick();
    end
    chk("send_timeout", 0, 1);
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 500 && expq.size() > 0; g++) tick();
    chk("drain_left", 64'(expq.size()), 0);
    tick();
  endtask

  longint rnd_vals[5] = '{131072, 65536, 65535, -65536, -65537};
  longint rnd_exp[5]  = '{1, 1, 0, 0, -1};

  initial begin
    int c0;
    longint v;
    logic [33:0] rv;

    // Reset and reset-state checks
    repeat (3) tick();
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_m_vld", 64'(m_tvalid), 0);
    chk("rst_m_dat", 64'(m_tdata), 0);
    chk("rst_sat_cnt", 64'(sat_count), 0);
    chk("rst_s_rdy", 64'(s_tready), 1);
    tick();

    // Rounding boundaries, ready held high
    obs.delete();
    foreach (rnd_vals[i]) send(rnd_vals[i]);
    drain();
    chk("round_cnt", 64'(obs.size()), 5);
    foreach (rnd_exp[i]) if (i < obs.size()) chk("round_val", obs[i], rnd_exp[i]);

    // Saturation in both directions, then clear coinciding with a third clamp
    obs.delete();
    send(64'sd8589934591);
    drain();
    chk("sat_pos_cnt", 64'(sat_count), 1);
    send(-64'sd8589934592);
    drain();
    chk("sat_neg_cnt", 64'(sat_count), 2);
    chk("sat_pos_val", obs.size() > 0 ? obs[0] : 0, 32767);
    chk("sat_neg_val", obs.size() > 1 ? obs[1] : 0, -32768);
    send(64'sd8589934591);
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    sat_acc = 1;
    drain();
    chk("sat_clr_evt", 64'(sat_count), 1);

    // Deterministic full / release
    m_tready = 1'b0;
    send(1000000);
    send(-2000000);
    @(negedge aclk);
    chk("full_rdy", 64'(s_tready), 0);
    tick();
    m_tready = 1'b1;
    @(negedge aclk);
    chk("release_rdy", 64'(s_tready), 1);
    drain();

    // Ramp under pseudo-random backpressure
    obs.delete();
    rnd_rdy = 1'b1;
    for (int i = 0; i < 10; i++) send(longint'(i) * 300000 - 1500000);
    drain();
    rnd_rdy = 1'b0;
    m_tready = 1'b1;
    chk("ramp_cnt", 64'(obs.size()), 10);
    for (int i = 0; i < 10 && i < obs.size(); i++)
      chk("ramp_val", obs[i], ref_out(longint'(i) * 300000 - 1500000));

    // Random values with random input gaps and output stalls
    rnd_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rv = {$urandom, $urandom};
      v = longint'($signed(rv)) >>> $urandom_range(0, 20);
      if ($urandom_range(0, 3) == 0) tick();
      send(v);
    end
    drain();
    rnd_rdy = 1'b0;
    m_tready = 1'b1;
    chk("rand_sat_cnt", 64'(sat_count), sat_acc);

    // Throughput: 100 back-to-back samples
    outcyc.delete();
    c0 = cyc;
    for (int i = 0; i < 100; i++) send(longint'(i) * 4096);
    chk("thr_in_cycles", 64'(cyc - c0), 100);
    drain();
    chk("thr_out_cnt", 64'(outcyc.size()), 100);
    if (outcyc.size() == 100) chk("thr_out_span", 64'(outcyc[99] - outcyc[0]), 99);

    // Reset with two samples in flight
    m_tready = 1'b0;
    send(64'sd8589934591);
    send(64'sd8589934591);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    sat_acc = 0;
    @(negedge aclk);
    chk("midrst_m_vld", 64'(m_tvalid), 0);
    chk("midrst_sat_cnt", 64'(sat_count), 0);
    m_tready = 1'b1;
    obs.delete();
    send(-300000);
    drain();
    chk("midrst_val", obs.size() > 0 ? obs[0] : 99999, ref_out(-300000));

    // Counter sticks at all-ones
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    sat_acc = 0;
    for (int i = 0; i < 65537; i++) send((i % 2) ? -64'sd8000000000 : 64'sd8000000000);
    drain();
    chk("sat_stick", 64'(sat_count), 65535);
    chk("sat_model", 64'(sat_count), sat_acc);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
